// File: rtl/result_reader_if.sv
// result_reader_if: element stream from result_reader to its downstream consumer.
//
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready.
// Once out_valid is high, out_data/out_index/out_last hold until that beat
// transfers; only abort or reset may withdraw out_valid early. out_ready may
// change freely and never combinationally depends on out_valid.
//
// Signals:
//   out_valid  master->slave  out_data holds element out_index
//   out_ready  slave->master  consumer accepts the beat
//   out_data   master->slave  DATA_LEN-bit element
//   out_index  master->slave  element number k
//   out_last   master->slave  beat carries element NUM_WORDS-1
interface result_reader_if #(
    parameter int DATA_LEN  = 10,
    parameter int NUM_WORDS = 960
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic [IDX_W-1:0]    out_index;
    logic                out_last;

    modport master (output out_valid, out_data, out_index, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/result_reader.sv
// result_reader: streams the flat result bus of the cube-processing core out
// one DATA_LEN-bit element per beat, lowest element first, and keeps a
// wrapping checksum of every element of a completed stream.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       one-cycle request to stream data_in (IDLE only)
//   abort       synchronous cancel; wins over start and over a transfer
//   data_in     NUM_WORDS*DATA_LEN result bus, held stable while busy
//   stream      element stream (master side of result_reader_if)
//   busy        a stream is in progress (SEND or FIN)
//   done        one-cycle pulse after the last beat transfers
//   checksum    sum of the elements of the last completed stream mod 2^SUM_W
//   dbg_state   current FSM state (0 IDLE, 1 SEND, 2 FIN)
module result_reader #(
    parameter int DATA_LEN  = 10,
    parameter int NUM_WORDS = 960,
    parameter int SUM_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_WORDS*DATA_LEN-1:0] data_in,
    result_reader_if.master               stream,
    output logic                          busy,
    output logic                          done,
    output logic [SUM_W-1:0]              checksum,
    output logic [1:0]                    dbg_state
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [SUM_W-1:0]    acc;
    logic [DATA_LEN-1:0] elem;
    logic                is_last;
    logic                xfer;

    // No snapshot of data_in: the element is selected live by the index.
    assign elem    = data_in[int'(idx) * DATA_LEN +: DATA_LEN];
    assign is_last = (idx == IDX_W'(NUM_WORDS - 1));
    // abort has priority over a transfer happening on the same edge.
    assign xfer    = (state == SEND) && stream.out_ready && !abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) state_nxt = SEND;
            end
            SEND: begin
                if (abort)                state_nxt = IDLE;
                else if (xfer && is_last) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stream.out_valid = (state == SEND);
        stream.out_data  = (state == SEND) ? elem : '0;
        stream.out_last  = (state == SEND) && is_last;
        stream.out_index = idx;
        busy             = (state != IDLE);
        // An abort during FIN cancels the completion, including its pulse.
        done             = (state == FIN) && !abort;
        dbg_state        = state;
    end

    // Index, accumulator and published checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            acc      <= '0;
            checksum <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                idx <= '0;
                acc <= '0;
            end else if (xfer) begin
                acc <= acc + SUM_W'(elem);
                // The index stops at the last element instead of wrapping.
                if (!is_last) idx <= idx + 1'b1;
            end
            if (state == FIN && !abort) checksum <= acc;
        end
    end
endmodule
